// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// Module : instr_sequencer_pkg
// Opcode map and sequencer state encoding shared by the MPS sequencer files.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

    // ALU operations sit on odd codes so opcode[0] doubles as the ALU select.
    localparam logic [3:0] OPCODE_NOP   = 4'h0;
    localparam logic [3:0] OPCODE_ADD   = 4'h1;
    localparam logic [3:0] OPCODE_SET   = 4'h2;
    localparam logic [3:0] OPCODE_SUB   = 4'h3;
    localparam logic [3:0] OPCODE_DUP   = 4'h4;
    localparam logic [3:0] OPCODE_AND   = 4'h5;
    localparam logic [3:0] OPCODE_LOAD  = 4'h6;
    localparam logic [3:0] OPCODE_OR    = 4'h7;
    localparam logic [3:0] OPCODE_STORE = 4'h8;
    localparam logic [3:0] OPCODE_XOR   = 4'h9;
    localparam logic [3:0] OPCODE_SHL   = 4'hB;
    localparam logic [3:0] OPCODE_SHR   = 4'hD;
    localparam logic [3:0] OPCODE_HCF   = 4'hE;
    localparam logic [3:0] OPCODE_NOT   = 4'hF;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_HALT   = 3'd5
    } seq_state_t;

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
    endfunction

    function automatic logic op_exec_writes(input logic [3:0] op);
        return op[0] || (op == OPCODE_SET) || (op == OPCODE_DUP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_counter.sv
// ============================================================================
// Module : seq_counter
// Enabled up-counter with selectable wrap-around or saturate-at-all-ones.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    generate
        if (SATURATE) begin : g_saturate
            always_comb begin
                w_next = (&r_count) ? r_count : r_count + 1'b1;
            end
        end else begin : g_wrap
            always_comb begin
                w_next = r_count + 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module : instr_sequencer
// Multi-cycle fetch/decode/execute sequencer sharing one memory port between
// instruction fetch and LOAD/STORE. Optional: MPS_SINGLE_STEP_EN adds 'step'.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef MPS_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       opcode,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             reg_d_we,
    output logic             alu_en,
    output logic             use_imm,
    output logic             mem_rd,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    seq_state_t r_state;
    seq_state_t w_next_state;
    logic       w_start;
    logic       w_pc_inc;
    logic       w_retire;

`ifdef MPS_SINGLE_STEP_EN
    logic r_step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
    end

    // A step launches one instruction; with run low it falls back to IDLE.
    assign w_start = run || (step && !r_step_q);
`else
    assign w_start = run;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        reg_d_we     = 1'b0;
        alu_en       = 1'b0;
        use_imm      = 1'b0;
        mem_rd       = 1'b0;
        halted       = 1'b0;
        w_pc_inc     = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            SEQ_IDLE: begin
                if (w_start) begin
                    w_next_state = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load      = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_next_state = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                if (opcode == OPCODE_HCF) begin
                    w_retire     = 1'b1;
                    w_next_state = SEQ_HALT;
                end else if (op_is_mem(opcode)) begin
                    w_next_state = SEQ_MEM;
                end else begin
                    w_next_state = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                alu_en       = opcode[0];
                use_imm      = (opcode == OPCODE_SET);
                reg_d_we     = op_exec_writes(opcode);
                w_retire     = 1'b1;
                w_next_state = run ? SEQ_FETCH : SEQ_IDLE;
            end
            SEQ_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OPCODE_STORE);
                if (mem_ack) begin
                    reg_d_we     = (opcode == OPCODE_LOAD);
                    mem_rd       = (opcode == OPCODE_LOAD);
                    w_retire     = 1'b1;
                    w_next_state = run ? SEQ_FETCH : SEQ_IDLE;
                end
            end
            SEQ_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = SEQ_IDLE;
            end
        endcase
    end

    seq_counter #(
        .WIDTH    (PC_W),
        .SATURATE (1'b0)
    ) u_pc_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_pc_inc),
        .count (pc)
    );

    seq_counter #(
        .WIDTH    (CNT_W),
        .SATURATE (1'b1)
    ) u_retired_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_retire),
        .count (retired)
    );

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle instruction sequencer for the MPS core.
- Fetches instructions from the single shared memory port and classifies the 4-bit opcode using the `OPCODE_*` constants in config.inc.v.
- Drives one-cycle enable pulses to the register file, ALU and memory.
- Arbitrates the one memory port between instruction fetch and LOAD/STORE data access; stops permanently on HCF until reset.

Parameters:
- PC_W, 8, program counter / fetch address width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute, 0 = pause at the next instruction boundary.
- opcode  in  4  instruction register [15:12], valid from DECODE onward.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0 = address from pc, 1 = address from datapath data address.
- mem_ack  in  1  one-cycle completion from memory.
- pc  out  PC_W  current fetch address.
- ir_load  out  1  capture memory read data into the instruction register.
- reg_d_we  out  1  write the destination register.
- alu_en  out  1  ALU result selected onto the write-back bus.
- use_imm  out  1  immediate selected onto the write-back bus.
- mem_rd  out  1  memory read data selected onto the write-back bus.
- halted  out  1  HCF has executed.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, pc = 0, retired = 0.
  - All outputs 0, including mem_req, which drops immediately.
  - A reset mid-transaction abandons the access; memory must tolerate request withdrawal.
- IDLE: all pulses 0. If run = 1, go to FETCH next cycle.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr_sel = 0.
  - On mem_ack: ir_load = 1 in that cycle, pc <= pc + 1 (wraps 2^PC_W-1 -> 0), go to DECODE.
  - Without ack, hold.
- DECODE: one cycle, no pulses.
  - opcode == HCF -> HALT.
  - LOAD or STORE -> MEM.
  - Otherwise -> EXEC.
- EXEC: one cycle.
  - alu_en = opcode[0].
  - use_imm = (opcode == SET).
  - reg_d_we = opcode[0] | SET | DUP.
  - Any other opcode is a no-op: no write.
  - retired++, then go to FETCH if run = 1, else IDLE.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = (opcode == STORE).
  - On mem_ack:
    - LOAD: reg_d_we = 1 and mem_rd = 1 in the ack cycle.
    - STORE: no register write.
    - retired++, then FETCH or IDLE per run.
  - Without ack, hold with all outputs stable.
- HALT:
  - halted = 1, no requests, run ignored; exit only via rst_n.
  - HCF counts as retired (incremented on the DECODE->HALT transition).
- Common rules:
  - mem_ack outside FETCH/MEM is ignored.
  - ir_load, reg_d_we, alu_en, use_imm and mem_rd are single-cycle pulses, never asserted together with ir_load.
  - run falling mid-instruction does not abort; the current instruction completes.
  - retired saturates at all-ones.
  - Minimum latency: ALU/SET/DUP = 3 cycles (FETCH, DECODE, EXEC) with zero-wait memory; LOAD/STORE = 3 cycles + data wait.

Optional Feature:
- Macro: MPS_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - When run = 0, a rising edge of step (registered edge detect) moves IDLE -> FETCH for exactly one instruction, which then returns to IDLE.
  - With run = 1, step is ignored.
- Undefined: no step port; IDLE leaves only on run = 1.

Decomposition:
- Shared package / config.inc.v:
  - `OPCODE_*` values.
  - State encoding constants: SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_EXEC, SEQ_MEM, SEQ_HALT (3-bit).
- One sub-module, seq_counter: parameterised width, enable, wrap/saturate select. Instantiated for pc (wrap) and retired (saturate).

Test Plan:
- Reset then run = 1, zero-wait memory, opcode SET at pc 0 -> ir_load at cycle 1, reg_d_we + use_imm at cycle 3, pc = 1, retired = 1.
- LOAD with mem_ack delayed 4 cycles in MEM -> mem_req/mem_addr_sel = 1 held 5 cycles, mem_we = 0, reg_d_we + mem_rd pulse in the ack cycle only.
- STORE then odd ALU opcode -> mem_we = 1 on the STORE access, no reg_d_we; ALU: alu_en = reg_d_we = 1 for one cycle; retired = 2.
- HCF at pc 5 -> halted = 1, retired = 6, pc = 6; toggle run and drive mem_ack -> no change; rst_n low -> all zero.
- pc = 2^PC_W-1 fetch -> pc wraps to 0; drop run during a 3-cycle MEM wait -> instruction completes, state IDLE, mem_req = 0.
- Async reset asserted mid-FETCH with mem_req = 1 -> mem_req = 0 before the next clock edge; after release with run = 1, fetch restarts at pc 0.
